// File: rtl/axi_rr_arbiter_pkg.sv
// axi_rr_arbiter_pkg: AXI request/response bundles, arbiter FSM states and owner-index width helper
package axi_rr_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } axi_req;
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi_resp;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_rr_arbiter_rr_picker.sv
// rr_picker: rotate-priority encoder returning the first requester at or after ptr (wrapping)
//   req   - request vector, one bit per master
//   ptr   - highest-priority index this round
//   found - any request present
//   idx   - chosen master index
module rr_picker import axi_rr_arbiter_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  localparam int IDX_W = idx_w(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  found,
  output logic [IDX_W-1:0]      idx
);
  always_comb begin
    int j;
    found = 1'b0;
    idx = '0;
    j = 0;
    // Scan from the farthest offset down so the nearest requester overwrites last.
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= NUM_INPUTS ? j - NUM_INPUTS : j;
      if (req[j]) begin
        found = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N-to-1 AXI master arbiter, independent round-robin read and write channels
//   clk, resetn - clock, asynchronous active-low reset
//   ireqs       - per-master request bundles
//   iresps      - per-master response bundles (zero for non-owners)
//   oreq        - request bundle to the bus
//   oresp       - response bundle from the bus
module axi_rr_arbiter import axi_rr_arbiter_pkg::*; #(
  parameter int NUM_INPUTS = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  axi_req  ireqs  [NUM_INPUTS],
  output axi_resp iresps [NUM_INPUTS],
  output axi_req  oreq,
  input  axi_resp oresp
);
  localparam int IDX_W = idx_w(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);
  rd_state_t r_state;
  wr_state_t w_state;
  logic [IDX_W-1:0] r_ptr, w_ptr, r_owner, w_owner, r_idx, w_idx;
  logic r_found, w_found, aw_done, w_done, aw_hs, w_hs;
  logic [NUM_INPUTS-1:0] r_req, w_req;
  axi_req r_sel, w_sel;
  always_comb begin
    r_req = '0;
    w_req = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      r_req[i] = ireqs[i].arvalid;
      w_req[i] = ireqs[i].awvalid | ireqs[i].wvalid;
    end
  end
  assign r_sel = ireqs[r_owner];
  assign w_sel = ireqs[w_owner];
  rr_picker #(.NUM_INPUTS(NUM_INPUTS)) u_r_pick (.req(r_req), .ptr(r_ptr), .found(r_found), .idx(r_idx));
  rr_picker #(.NUM_INPUTS(NUM_INPUTS)) u_w_pick (.req(w_req), .ptr(w_ptr), .found(w_found), .idx(w_idx));
  // Completed AW/W halves are masked so the bus never sees a second handshake.
  always_comb begin
    oreq = '0;
    if (r_state == R_ADDR) begin
      oreq.arid = r_sel.arid;
      oreq.araddr = r_sel.araddr;
      oreq.arlen = r_sel.arlen;
      oreq.arsize = r_sel.arsize;
      oreq.arburst = r_sel.arburst;
      oreq.arvalid = r_sel.arvalid;
    end
    if (r_state == R_DATA) oreq.rready = r_sel.rready;
    if (w_state == W_ADDR) begin
      oreq.awid = w_sel.awid;
      oreq.awaddr = w_sel.awaddr;
      oreq.awlen = w_sel.awlen;
      oreq.awsize = w_sel.awsize;
      oreq.awburst = w_sel.awburst;
      oreq.awvalid = w_sel.awvalid & ~aw_done;
      oreq.wdata = w_sel.wdata;
      oreq.wstrb = w_sel.wstrb;
      oreq.wlast = w_sel.wlast;
      oreq.wvalid = w_sel.wvalid & ~w_done;
    end
    if (w_state == W_RESP) oreq.bready = w_sel.bready;
  end
  assign aw_hs = oreq.awvalid & oresp.awready;
  assign w_hs = oreq.wvalid & oresp.wready & oreq.wlast;
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
      if (r_state == R_ADDR && r_owner == IDX_W'(i)) iresps[i].arready = oresp.arready;
      if (r_state == R_DATA && r_owner == IDX_W'(i)) begin
        iresps[i].rid = oresp.rid;
        iresps[i].rdata = oresp.rdata;
        iresps[i].rresp = oresp.rresp;
        iresps[i].rlast = oresp.rlast;
        iresps[i].rvalid = oresp.rvalid;
      end
      if (w_state == W_ADDR && w_owner == IDX_W'(i)) begin
        iresps[i].awready = oresp.awready & ~aw_done;
        iresps[i].wready = oresp.wready & ~w_done;
      end
      if (w_state == W_RESP && w_owner == IDX_W'(i)) begin
        iresps[i].bid = oresp.bid;
        iresps[i].bresp = oresp.bresp;
        iresps[i].bvalid = oresp.bvalid;
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_ptr <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (r_found) begin
          r_owner <= r_idx;
          r_state <= R_ADDR;
        end
        R_ADDR: r_state <= !r_sel.arvalid ? R_IDLE : oresp.arready ? R_DATA : R_ADDR;
        R_DATA: if (oresp.rvalid && r_sel.rready && oresp.rlast) begin
          r_state <= R_IDLE;
          r_ptr <= r_owner == LAST ? '0 : r_owner + 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_ptr <= '0;
      w_owner <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (w_found) begin
          w_owner <= w_idx;
          w_state <= W_ADDR;
          aw_done <= 1'b0;
          w_done <= 1'b0;
        end
        W_ADDR: begin
          aw_done <= aw_done | aw_hs;
          w_done <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) w_state <= W_RESP;
        end
        W_RESP: if (oresp.bvalid && w_sel.bready) begin
          w_state <= W_IDLE;
          w_ptr <= w_owner == LAST ? '0 : w_owner + 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed self-checking bench for axi_rr_arbiter with four masters
module tb_axi_rr_arbiter;
  import axi_rr_arbiter_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  axi_req  ireqs  [4];
  axi_resp iresps [4];
  axi_req  oreq;
  axi_resp oresp;
  int passed = 0;
  int fails = 0;
  int total = 0;
  always #5 clk = ~clk;
  axi_rr_arbiter #(.NUM_INPUTS(4)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < 4; i++) ireqs[i] = '0;
    oresp = '0;
  endtask
  task automatic rd(input int m, input int beats);
    int n = 0;
    while (!oreq.arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("ar_wait", 256'(n < 20), 256'(1));
    chk("ar_owner", 256'(oreq.arid), 256'(8 + m));
    oresp.arready = 1'b1;
    #1;
    chk("ar_ready_own", 256'(iresps[m].arready), 256'(1));
    chk("ar_ready_iso", 256'(iresps[(m + 1) % 4].arready), 256'(0));
    tick();
    oresp.arready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      oresp.rvalid = 1'b1;
      oresp.rdata = 32'hd000 + b;
      oresp.rlast = b == beats - 1;
      #1;
      chk("r_data_own", 256'(iresps[m].rdata), 256'(32'hd000 + b));
      chk("r_valid_iso", 256'(iresps[(m + 1) % 4].rvalid), 256'(0));
      tick();
    end
    oresp.rvalid = 1'b0;
    oresp.rlast = 1'b0;
    #1;
    chk("r_done", 256'(oreq.rready), 256'(0));
  endtask
  initial begin
    clr();
    for (int i = 0; i < 4; i++) begin
      ireqs[i].arvalid = 1'b1;
      ireqs[i].arid = 4'(8 + i);
      ireqs[i].rready = 1'b1;
    end
    oresp.arready = 1'b1;
    oresp.rvalid = 1'b1;
    oresp.bvalid = 1'b1;
    repeat (3) tick();
    chk("rst_oreq", 256'(oreq), 256'(0));
    chk("rst_iresps", 256'({iresps[0], iresps[1], iresps[2], iresps[3]}), 256'(0));
    oresp = '0;
    resetn = 1'b1;
    #1;
    chk("grant_latency", 256'(oreq.arvalid), 256'(0));
    tick();
    chk("rst_grant_valid", 256'(oreq.arvalid), 256'(1));
    chk("rst_grant_owner", 256'(oreq.arid), 256'(8));
    ireqs[3].arvalid = 1'b0;
    rd(0, 1);
    rd(1, 1);
    rd(2, 1);
    rd(0, 1);
    for (int t = 0; t < 8; t++) rd((t + 1) % 3, 1);
    clr();
    tick();
    ireqs[1].arvalid = 1'b1;
    ireqs[1].arid = 4'd9;
    ireqs[1].arlen = 8'd3;
    ireqs[1].rready = 1'b1;
    ireqs[1].bready = 1'b1;
    ireqs[2].awvalid = 1'b1;
    ireqs[2].awid = 4'd5;
    ireqs[2].awlen = 8'd1;
    ireqs[2].wvalid = 1'b1;
    ireqs[2].wdata = 32'ha1;
    ireqs[2].bready = 1'b1;
    ireqs[2].rready = 1'b1;
    tick();
    chk("cc_arvalid", 256'(oreq.arvalid), 256'(1));
    chk("cc_arid", 256'(oreq.arid), 256'(9));
    chk("cc_arlen", 256'(oreq.arlen), 256'(3));
    chk("cc_awvalid", 256'(oreq.awvalid), 256'(1));
    chk("cc_awid", 256'(oreq.awid), 256'(5));
    chk("cc_wdata", 256'(oreq.wdata), 256'(32'ha1));
    oresp.arready = 1'b1;
    oresp.awready = 1'b1;
    oresp.wready = 1'b1;
    tick();
    ireqs[1].arvalid = 1'b0;
    ireqs[2].awvalid = 1'b0;
    ireqs[2].wdata = 32'ha2;
    ireqs[2].wlast = 1'b1;
    oresp.arready = 1'b0;
    oresp.awready = 1'b0;
    oresp.rvalid = 1'b1;
    oresp.rdata = 32'hbeef;
    #1;
    chk("cc_wready", 256'(iresps[2].wready), 256'(1));
    chk("cc_r_own", 256'(iresps[1].rvalid), 256'(1));
    chk("cc_r_iso", 256'(iresps[2].rvalid), 256'(0));
    tick();
    ireqs[2].wvalid = 1'b0;
    oresp.bvalid = 1'b1;
    oresp.bid = 4'd5;
    #1;
    chk("cc_b_own", 256'(iresps[2].bvalid), 256'(1));
    chk("cc_bid", 256'(iresps[2].bid), 256'(5));
    chk("cc_b_iso", 256'(iresps[1].bvalid), 256'(0));
    chk("cc_r_iso2", 256'(iresps[2].rvalid), 256'(0));
    tick();
    oresp.bvalid = 1'b0;
    tick();
    oresp.rlast = 1'b1;
    #1;
    chk("cc_rlast", 256'(iresps[1].rlast), 256'(1));
    tick();
    chk("cc_r_end", 256'(iresps[1].rvalid), 256'(0));
    chk("cc_w_idle", 256'(oreq.bready), 256'(0));
    clr();
    tick();
    ireqs[0].awvalid = 1'b1;
    ireqs[0].awid = 4'd6;
    ireqs[0].wvalid = 1'b1;
    ireqs[0].wlast = 1'b1;
    ireqs[0].bready = 1'b1;
    oresp.wready = 1'b1;
    tick();
    chk("sk_wvalid", 256'(oreq.wvalid), 256'(1));
    chk("sk_owner_wrap", 256'(oreq.awid), 256'(6));
    tick();
    chk("sk_wforce", 256'(oreq.wvalid), 256'(0));
    ireqs[0].wvalid = 1'b0;
    tick();
    tick();
    chk("sk_awvalid", 256'(oreq.awvalid), 256'(1));
    chk("sk_no_resp", 256'(oreq.bready), 256'(0));
    oresp.awready = 1'b1;
    tick();
    oresp.awready = 1'b0;
    chk("sk_resp", 256'(oreq.bready), 256'(1));
    chk("sk_awforce", 256'(oreq.awvalid), 256'(0));
    oresp.bvalid = 1'b1;
    tick();
    clr();
    tick();
    ireqs[2].arvalid = 1'b1;
    ireqs[2].arid = 4'd10;
    ireqs[3].arvalid = 1'b1;
    ireqs[3].arid = 4'd11;
    ireqs[3].rready = 1'b1;
    ireqs[3].arlen = 8'd3;
    tick();
    chk("ab_grant2", 256'(oreq.arid), 256'(10));
    ireqs[2].arvalid = 1'b0;
    #1;
    chk("ab_drop", 256'(oreq.arvalid), 256'(0));
    tick();
    tick();
    chk("ab_grant3_valid", 256'(oreq.arvalid), 256'(1));
    chk("ab_grant3_id", 256'(oreq.arid), 256'(11));
    oresp.arready = 1'b1;
    tick();
    oresp.arready = 1'b0;
    ireqs[3].arvalid = 1'b0;
    oresp.rvalid = 1'b1;
    tick();
    #2;
    chk("mb_beat2", 256'(iresps[3].rvalid), 256'(1));
    resetn = 1'b0;
    #1;
    chk("mb_rst_oreq", 256'(oreq), 256'(0));
    chk("mb_rst_iresps", 256'({iresps[0], iresps[1], iresps[2], iresps[3]}), 256'(0));
    clr();
    ireqs[1].arvalid = 1'b1;
    ireqs[1].arid = 4'd9;
    ireqs[3].arvalid = 1'b1;
    ireqs[3].arid = 4'd11;
    ireqs[0].awvalid = 1'b1;
    ireqs[0].awid = 4'd6;
    ireqs[2].awvalid = 1'b1;
    ireqs[2].awid = 4'd5;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("ptr_r_reset", 256'(oreq.arid), 256'(9));
    chk("ptr_w_reset", 256'(oreq.awid), 256'(6));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
